// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared types and sizing helpers for the PISO serializer.
//
// Optional feature macro: PISO_PARITY_EN
//   defined   -> every frame carries a trailing even-parity bit (L = N+1)
//   undefined -> frames carry the data bits only (L = N)
// -----------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef PISO_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Bits per serial frame for an n-bit word.
  function automatic int unsigned frame_len(input int unsigned n);
    return n + PARITY_BITS;
  endfunction

  // Counter width able to hold L-1 with or without the parity bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_bit_counter
// Up-counter over the bit positions of a frame, with synchronous clear and a
// terminal-count flag raised while the count sits on the last frame bit.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (count -> 0)
//   clr_i  clear to 0 on the next edge (wins over en_i)
//   en_i   advance by one on the next edge
//   tc_o   count == LEN-1
// -----------------------------------------------------------------------------
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned LEN = 4,
  parameter int unsigned W   = cnt_width(LEN)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [W-1:0] LAST = W'(LEN - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves count_d
    // unassigned; otherwise synthesis infers a latch.
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in serial-out transmitter. Accepts an N-bit word over a valid/ready
// handshake and shifts it out one bit per clock, framed by ser_valid/ser_last.
// Back-to-back frames run without a gap: in_ready rises on the last-bit cycle.
//
// Optional feature macro: PISO_PARITY_EN (appends an even-parity bit).
//
// Parameters:
//   N          word width (N >= 2)
//   MSB_FIRST  1: bit N-1 leaves first; 0: bit 0 leaves first
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any frame in flight
//   par_in     parallel word, captured on the accepting edge
//   in_valid   par_in holds a word to accept
//   in_ready   a word can be accepted this cycle
//   ser_out    current serial bit
//   ser_valid  ser_out carries a frame bit
//   ser_last   ser_out is the final bit of the frame
//   busy       frame in progress
//
// All outputs decode registered state only.
// -----------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] par_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_last,
  output logic         busy
);

  localparam int unsigned L  = frame_len(N);
  localparam int unsigned CW = cnt_width(N);

  state_e       state_q, state_d;
  logic [N-1:0] shift_q, shift_d;
  logic         tc;
  logic         accept;
  logic         shifting;
  logic         data_bit;
  logic         tx_bit;

  assign accept   = in_valid & in_ready;
  assign shifting = (state_q == SHIFT);

  // Counter is cleared on every accept and after the last bit, so it reads 0
  // whenever the block is idle.
  piso_bit_counter #(
    .LEN (L),
    .W   (CW)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept | (shifting & tc)),
    .en_i  (shifting),
    .tc_o  (tc)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (tc)     state_d = accept ? SHIFT : IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------- datapath
  // Shift toward the output end with zero fill; a reload overrides the shift.
  always_comb begin
    shift_d = shift_q;
    if (accept) begin
      shift_d = par_in;
    end else if (shifting) begin
      shift_d = MSB_FIRST ? {shift_q[N-2:0], 1'b0} : {1'b0, shift_q[N-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign data_bit = MSB_FIRST ? shift_q[N-1] : shift_q[0];

`ifdef PISO_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = accept ? ^par_in : parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  // The parity bit is the final frame bit, so the terminal count marks it.
  assign tx_bit = tc ? parity_q : data_bit;
`else
  assign tx_bit = data_bit;
`endif

  // ----------------------------------------------------------------- outputs
  always_comb begin
    in_ready  = 1'b0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_out   = tx_bit;
        ser_last  = tc;
        in_ready  = tc;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Two instances: u_dut_m (MSB_FIRST=1) and u_dut_l (MSB_FIRST=0), N=4.
// Stimulus pushes the hand-computed bit stream of each word into a per-DUT
// queue; a monitor per DUT pops and compares on every ser_valid cycle.
// Handshake timing, back-to-back spacing and asynchronous reset are checked
// directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int N = 4;
`ifdef PISO_PARITY_EN
  localparam int L = 5;
`else
  localparam int L = 4;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] par_in_m = '0, par_in_l = '0;
  logic       in_valid_m = 1'b0, in_valid_l = 1'b0;
  logic       in_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m;
  logic       in_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l;

  int    cyc = 0;
  int    n_pass = 0;
  int    n_total = 0;
  beat_t q_m[$];
  beat_t q_l[$];
  beat_t e_m, e_l;

  piso_serializer #(.N(N), .MSB_FIRST(1'b1)) u_dut_m (
    .clk       (clk),
    .rst_n     (rst_n),
    .par_in    (par_in_m),
    .in_valid  (in_valid_m),
    .in_ready  (in_ready_m),
    .ser_out   (ser_out_m),
    .ser_valid (ser_valid_m),
    .ser_last  (ser_last_m),
    .busy      (busy_m)
  );

  piso_serializer #(.N(N), .MSB_FIRST(1'b0)) u_dut_l (
    .clk       (clk),
    .rst_n     (rst_n),
    .par_in    (par_in_l),
    .in_valid  (in_valid_l),
    .in_ready  (in_ready_l),
    .ser_out   (ser_out_l),
    .ser_valid (ser_valid_l),
    .ser_last  (ser_last_l),
    .busy      (busy_l)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // bits[len-1] is the first bit on the wire.
  task automatic push(input bit sel, input logic [7:0] bits, input int len, input bit last_at_end);
    beat_t be;
    for (int i = 0; i < len; i++) begin
      be.b    = bits[len-1-i];
      be.last = last_at_end && (i == len - 1);
      if (sel) q_l.push_back(be);
      else     q_m.push_back(be);
    end
  endtask

  // data: the four data bits in wire order; par: hand-computed parity bit,
  // appended only when the parity feature is built in.
  task automatic push_frame(input bit sel, input logic [3:0] data, input logic par);
    logic [7:0] v;
    v = {3'b000, data, par};
`ifdef PISO_PARITY_EN
    push(sel, v, 5, 1'b1);
`else
    push(sel, v >> 1, 4, 1'b1);
`endif
  endtask

  // Call just after a posedge. Returns just after the accepting edge.
  task automatic send(input bit sel, input logic [3:0] w, input bit hold, output int acc_cyc);
    bit rdy;
    int waited;
    rdy    = 1'b0;
    waited = 0;
    if (sel) begin par_in_l = w; in_valid_l = 1'b1; end
    else     begin par_in_m = w; in_valid_m = 1'b1; end
    while (!rdy && waited < 20) begin
      @(negedge clk);
      rdy = sel ? in_ready_l : in_ready_m;
      @(posedge clk);
      waited++;
    end
    #1;
    acc_cyc = cyc;
    if (!rdy) check("accept_timeout", 32'd0, 32'd1);
    if (!hold) begin
      if (sel) in_valid_l = 1'b0;
      else     in_valid_m = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin
    if (ser_valid_m) begin
      if (q_m.size() == 0) begin
        check("m_unexpected_bit", 32'd1, 32'd0);
      end else begin
        e_m = q_m.pop_front();
        check("m_ser_out", ser_out_m, e_m.b);
        check("m_ser_last", ser_last_m, e_m.last);
      end
    end else begin
      check("m_last_when_idle", ser_last_m, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (ser_valid_l) begin
      if (q_l.size() == 0) begin
        check("l_unexpected_bit", 32'd1, 32'd0);
      end else begin
        e_l = q_l.pop_front();
        check("l_ser_out", ser_out_l, e_l.b);
        check("l_ser_last", ser_last_l, e_l.last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int t0, t1, t;

    // Reset state, sampled while reset is still held.
    #12;
    check("rst_in_ready", in_ready_m, 1'b1);
    check("rst_ser_out", ser_out_m, 1'b0);
    check("rst_ser_valid", ser_valid_m, 1'b0);
    check("rst_ser_last", ser_last_m, 1'b0);
    check("rst_busy", busy_m, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word 1011, MSB first: wire 1,0,1,1 (parity 1).
    push_frame(1'b0, 4'b1011, 1'b1);
    send(1'b0, 4'b1011, 1'b0, t);
    for (int k = 1; k <= L; k++) begin
      check($sformatf("t1_in_ready_c%0d", k), in_ready_m, (k == L));
      check($sformatf("t1_busy_c%0d", k), busy_m, 1'b1);
      @(posedge clk);
      #1;
    end
    check("t1_idle_busy", busy_m, 1'b0);
    check("t1_idle_ready", in_ready_m, 1'b1);

    // Back-to-back A then 5: wire 1,0,1,0 | 0,1,0,1 (both parities 0).
    push_frame(1'b0, 4'b1010, 1'b0);
    push_frame(1'b0, 4'b0101, 1'b0);
    send(1'b0, 4'hA, 1'b1, t0);
    send(1'b0, 4'h5, 1'b0, t1);
    check("t2_no_gap", t1 - t0, L);
    check("t2_busy_frame2", busy_m, 1'b1);
    idle_cycles(L);
    check("t2_idle_busy", busy_m, 1'b0);

    // LSB first, word 0001: wire 1,0,0,0 (parity 1).
    push_frame(1'b1, 4'b1000, 1'b1);
    send(1'b1, 4'b0001, 1'b0, t);
    idle_cycles(L);
    check("t3_idle_busy", busy_l, 1'b0);

    // 4'hF offered while busy is ignored; 3 -> wire 0,0,1,1 (parity 0).
    push_frame(1'b0, 4'b0011, 1'b0);
    send(1'b0, 4'h3, 1'b0, t);
    @(posedge clk);
    #1;
    par_in_m   = 4'hF;
    in_valid_m = 1'b1;
    check("t4_ready_low_c2", in_ready_m, 1'b0);
    @(posedge clk);
    #1;
    in_valid_m = 1'b0;
    idle_cycles(L);
    check("t4_idle_busy", busy_m, 1'b0);

    // Asynchronous reset during bit 2 of 4'hC: only bit 1 (a '1') is seen.
    push(1'b0, 8'b0000_0001, 1, 1'b0);
    send(1'b0, 4'hC, 1'b0, t);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_ser_valid", ser_valid_m, 1'b0);
    check("t5_rst_ser_last", ser_last_m, 1'b0);
    check("t5_rst_busy", busy_m, 1'b0);
    check("t5_rst_in_ready", in_ready_m, 1'b1);
    check("t5_rst_ser_out", ser_out_m, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t5_post_rst_busy", busy_m, 1'b0);
    push_frame(1'b0, 4'b1001, 1'b0);
    send(1'b0, 4'h9, 1'b0, t);
    idle_cycles(L);

    // 0111 -> parity 1; 0110 -> parity 0.
    push_frame(1'b0, 4'b0111, 1'b1);
    send(1'b0, 4'b0111, 1'b0, t);
    idle_cycles(L);
    push_frame(1'b0, 4'b0110, 1'b0);
    send(1'b0, 4'b0110, 1'b0, t);
    idle_cycles(L + 2);

    check("m_queue_drained", q_m.size(), 32'd0);
    check("l_queue_drained", q_l.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
